seg7_scan_capture: RTL and testbench

// - Receive side of our 7-segment display path: watches a multiplexed (scanned) segment bus plus digit strobes,

---
 rtl/seg7_scan_capture_pkg.sv | 23 ++
 rtl/seg7_scan_capture_if.sv | 24 ++
 rtl/seg7_scan_capture_decode.sv | 28 ++
 rtl/seg7_scan_capture.sv | 161 ++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_capture_pkg.sv
// Shared constants for the scanned 7-segment capture path: bus bit positions,
// the hex glyph table (a..g order, MSB = a) and the frame-assembly state encoding.
package seg7_scan_capture_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] HEX_PAT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Scanned segment bus in, decoded frame out with valid/ready handshake.
// master = capture block, slave = bus driver / frame consumer.
interface seg7_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic [4*NUM_DIGITS-1:0] out_value;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sync_err;
  logic                    overrun;

  modport master (
    input  seg_in, dig_en, out_ready,
    output out_value, out_err, out_valid, sync_err, overrun
  );

  modport slave (
    output seg_in, dig_en, out_ready,
    input  out_value, out_err, out_valid, sync_err, overrun
  );
endinterface

// File: rtl/seg7_scan_capture_decode.sv
// Combinational glyph decoder: 7-bit segment pattern -> hex nibble, with a flag
// for patterns that are not one of the 16 hex glyphs.
module seg7_pattern_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nib_o,
  output logic       inv_o
);

  logic [6:0] abcdefg;

  // Table is stored a..g from MSB; gather bus bits into that order explicitly.
  assign abcdefg = {pat_i[SEG_A], pat_i[SEG_B], pat_i[SEG_C], pat_i[SEG_D],
                    pat_i[SEG_E], pat_i[SEG_F], pat_i[SEG_G]};

  always_comb begin
    nib_o = 4'h0;
    inv_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (abcdefg == HEX_PAT[i]) begin
        nib_o = 4'(i);
        inv_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Watches a scanned 7-segment bus, debounces each digit slot, decodes it and
// assembles in-order frames into a held valid/ready output word.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_capture_if.master  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam int IN_W  = 7 + NUM_DIGITS;
  localparam int FRM_W = 4 * NUM_DIGITS;

  logic [IN_W-1:0]  in_now, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed, stable_hit, dig_any, dig_multi, cap, cap_multi;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib;
  logic             inv;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] exp_q, exp_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic             ferr_q, ferr_d;
  logic             complete, sync_d;

  logic [FRM_W-1:0] out_value_q, out_value_d;
  logic             out_err_q, out_err_d, out_valid_q, out_valid_d;
  logic             sync_q, ovr_q, ovr_d;

  assign in_now  = {bus.seg_in, bus.dig_en};
  assign changed = (in_now != prev_q);

  // Counter saturates one past the capture point so a held slot fires only once.
  assign cnt_d = changed                                 ? '0 :
                 (cnt_q == CNT_W'(STABLE_CYCLES - 1))    ? cnt_q :
                                                           cnt_q + CNT_W'(1);
  assign stable_hit = !changed && (cnt_q == CNT_W'(STABLE_CYCLES - 2));

  assign dig_any   = |bus.dig_en;
  assign dig_multi = (bus.dig_en & (bus.dig_en - NUM_DIGITS'(1))) != '0;
  assign cap       = stable_hit && dig_any && !dig_multi;
  assign cap_multi = stable_hit && dig_multi;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.dig_en[i]) idx = IDX_W'(i);
    end
  end

  seg7_pattern_decode u_dec (
    .pat_i (bus.seg_in),
    .nib_o (nib),
    .inv_o (inv)
  );

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    frame_d  = frame_q;
    ferr_d   = ferr_q;
    complete = 1'b0;
    sync_d   = 1'b0;
    if (cap_multi) begin
      sync_d  = 1'b1;
      state_d = HUNT;
      frame_d = '0;
      ferr_d  = 1'b0;
    end else if (cap) begin
      if (state_q == HUNT || (idx == '0 && idx != exp_q)) begin
        if (idx == '0) begin
          sync_d        = (state_q == COLLECT);
          frame_d       = '0;
          frame_d[3:0]  = nib;
          ferr_d        = inv;
          exp_d         = IDX_W'(1);
          if (NUM_DIGITS == 1) begin
            complete = 1'b1;
            state_d  = HUNT;
          end else begin
            state_d  = COLLECT;
          end
        end
      end else if (idx == exp_q) begin
        frame_d[4*idx +: 4] = nib;
        ferr_d              = ferr_q | inv;
        if (exp_q == IDX_W'(NUM_DIGITS - 1)) begin
          complete = 1'b1;
          state_d  = HUNT;
        end else begin
          exp_d = exp_q + IDX_W'(1);
        end
      end else begin
        sync_d  = 1'b1;
        state_d = HUNT;
        frame_d = '0;
        ferr_d  = 1'b0;
      end
    end
  end

  // A completed frame only lands if the holding register is free or being drained.
  always_comb begin
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    ovr_d       = 1'b0;
    if (complete) begin
      if (!out_valid_q || bus.out_ready) begin
        out_value_d = frame_d;
        out_err_d   = ferr_d;
        out_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      state_q     <= HUNT;
      exp_q       <= '0;
      frame_q     <= '0;
      ferr_q      <= 1'b0;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sync_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      prev_q      <= in_now;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      exp_q       <= exp_d;
      frame_q     <= frame_d;
      ferr_q      <= ferr_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      sync_q      <= sync_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.out_value = out_value_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err  = sync_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed and randomized scan sequences against a slot/frame-level reference
// model; every cycle the model's expected outputs are compared with the DUT.
module tb_seg7_scan_capture;

  localparam int ND = 4;
  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int ncmp  = 0;
  int nfail = 0;

  logic [6:0] pat_tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference model state
  logic        rdy;
  bit          rand_rdy;
  logic [10:0] prev_in;
  int          run;
  int          m_expect;
  logic [3:0]  m_frame [ND];
  logic        m_ferr;
  logic        m_valid, m_err, m_sync, m_ovr;
  logic [15:0] m_value;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_value  = '0;
    m_err    = 1'b0;
    m_sync   = 1'b0;
    m_ovr    = 1'b0;
    m_expect = -1;
    m_ferr   = 1'b0;
    for (int i = 0; i < ND; i++) m_frame[i] = 4'h0;
    prev_in  = '0;
    run      = 1;
  endtask

  task automatic decode(input logic [6:0] s, output logic [3:0] n, output logic bad);
    n   = 4'h0;
    bad = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pat_tab[i] == s) begin
        n   = 4'(i);
        bad = 1'b0;
      end
    end
  endtask

  task automatic model_cycle(input logic [6:0] seg, input logic [3:0] dig, input logic r);
    logic [3:0] n;
    logic       bad, cap, complete;
    int         idx;
    if ({seg, dig} != prev_in) run = 1;
    else run++;
    prev_in  = {seg, dig};
    cap      = (run == SC);
    complete = 1'b0;
    m_sync   = 1'b0;
    m_ovr    = 1'b0;
    if (cap && $countones(dig) > 1) begin
      m_sync   = 1'b1;
      m_expect = -1;
    end else if (cap && dig != 0) begin
      idx = 0;
      for (int i = 0; i < ND; i++) if (dig[i]) idx = i;
      decode(seg, n, bad);
      if (m_expect < 0 || (idx == 0 && m_expect != 0)) begin
        if (idx == 0) begin
          if (m_expect >= 0) m_sync = 1'b1;
          m_frame[0] = n;
          m_ferr     = bad;
          m_expect   = 1;
        end
      end else if (idx == m_expect) begin
        m_frame[idx] = n;
        m_ferr       = m_ferr | bad;
        m_expect++;
      end else begin
        m_sync   = 1'b1;
        m_expect = -1;
      end
      if (m_expect == ND) begin
        complete = 1'b1;
        m_expect = -1;
      end
    end
    if (complete) begin
      if (!m_valid || r) begin
        for (int i = 0; i < ND; i++) m_value[4*i +: 4] = m_frame[i];
        m_err   = m_ferr;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic [6:0] seg, input logic [3:0] dig);
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    bus.seg_in    = seg;
    bus.dig_en    = dig;
    bus.out_ready = rdy;
    model_cycle(seg, dig, rdy);
    @(posedge clk);
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_value", 32'(bus.out_value), 32'(m_value));
    check("out_err",   32'(bus.out_err),   32'(m_err));
    check("sync_err",  32'(bus.sync_err),  32'(m_sync));
    check("overrun",   32'(bus.overrun),   32'(m_ovr));
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    repeat (n) step(s, d);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [6:0]  rs;
  logic [3:0]  rd;
  logic [10:0] last_drv;
  int          nxt;
  int          r;

  initial begin
    rst           = 1'b1;
    rdy           = 1'b1;
    rand_rdy      = 1'b0;
    bus.seg_in    = '0;
    bus.dig_en    = '0;
    bus.out_ready = 1'b1;
    model_reset();
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_value", 32'(bus.out_value), 32'h0);
    check("rst_err",   32'(bus.out_err),   32'h0);
    check("rst_sync",  32'(bus.sync_err),  32'h0);
    check("rst_ovr",   32'(bus.overrun),   32'h0);
    apply_reset();

    // Basic in-order frame
    hold(7'h7E, 4'b0001, 6);
    hold(7'h30, 4'b0010, 6);
    hold(7'h6D, 4'b0100, 6);
    hold(7'h79, 4'b1000, 4);
    check("basic_valid", 32'(bus.out_valid), 32'h1);
    check("basic_value", 32'(bus.out_value), 32'h3210);
    check("basic_err",   32'(bus.out_err),   32'h0);
    hold(7'h79, 4'b1000, 1);
    check("basic_drop",  32'(bus.out_valid), 32'h0);
    hold(7'h79, 4'b1000, 1);

    // Glitched digit 1 must be captured exactly once
    hold(7'h7E, 4'b0001, 6);
    hold(7'h30, 4'b0010, 3);
    hold(7'h00, 4'b0000, 1);
    hold(7'h30, 4'b0010, 6);
    hold(7'h6D, 4'b0100, 6);
    hold(7'h79, 4'b1000, 4);
    check("glitch_value", 32'(bus.out_value), 32'h3210);
    check("glitch_valid", 32'(bus.out_valid), 32'h1);
    hold(7'h79, 4'b1000, 2);

    // Undecodable digit 2, then a clean frame
    hold(7'h7E, 4'b0001, 6);
    hold(7'h30, 4'b0010, 6);
    hold(7'h00, 4'b0100, 6);
    hold(7'h79, 4'b1000, 4);
    check("inv_value", 32'(bus.out_value), 32'h3010);
    check("inv_err",   32'(bus.out_err),   32'h1);
    hold(7'h79, 4'b1000, 2);
    hold(7'h4E, 4'b0001, 6);
    hold(7'h3D, 4'b0010, 6);
    hold(7'h4F, 4'b0100, 6);
    hold(7'h47, 4'b1000, 4);
    check("clean_value", 32'(bus.out_value), 32'hFEDC);
    check("clean_err",   32'(bus.out_err),   32'h0);
    hold(7'h47, 4'b1000, 2);

    // Scan order broken, then restart on digit 0
    hold(7'h7E, 4'b0001, 6);
    hold(7'h30, 4'b0010, 6);
    hold(7'h79, 4'b1000, 4);
    check("order_sync",  32'(bus.sync_err),  32'h1);
    check("order_novld", 32'(bus.out_valid), 32'h0);
    hold(7'h79, 4'b1000, 2);
    hold(7'h7E, 4'b0001, 6);
    hold(7'h30, 4'b0010, 6);
    hold(7'h33, 4'b0001, 4);
    check("restart_sync", 32'(bus.sync_err), 32'h1);
    hold(7'h33, 4'b0001, 2);
    hold(7'h30, 4'b0010, 6);
    hold(7'h6D, 4'b0100, 6);
    hold(7'h79, 4'b1000, 4);
    check("restart_value", 32'(bus.out_value), 32'h3214);
    hold(7'h79, 4'b1000, 2);

    // Backpressure: second frame overruns, third loads on the accepting edge
    rdy = 1'b0;
    hold(7'h5F, 4'b0001, 6);
    hold(7'h70, 4'b0010, 6);
    hold(7'h7F, 4'b0100, 6);
    hold(7'h7B, 4'b1000, 6);
    check("bp_first", 32'(bus.out_value), 32'h9876);
    hold(7'h7E, 4'b0001, 6);
    hold(7'h30, 4'b0010, 6);
    hold(7'h6D, 4'b0100, 6);
    hold(7'h79, 4'b1000, 4);
    check("bp_overrun", 32'(bus.overrun),   32'h1);
    check("bp_held",    32'(bus.out_value), 32'h9876);
    hold(7'h79, 4'b1000, 1);
    check("bp_ovr_pulse", 32'(bus.overrun),  32'h0);
    check("bp_still_vld", 32'(bus.out_valid), 32'h1);
    hold(7'h77, 4'b0001, 6);
    hold(7'h1F, 4'b0010, 6);
    hold(7'h4E, 4'b0100, 6);
    hold(7'h3D, 4'b1000, 3);
    rdy = 1'b1;
    hold(7'h3D, 4'b1000, 1);
    check("b2b_valid", 32'(bus.out_valid), 32'h1);
    check("b2b_value", 32'(bus.out_value), 32'hDCBA);
    hold(7'h3D, 4'b1000, 1);
    check("b2b_drain", 32'(bus.out_valid), 32'h0);

    // Asynchronous reset mid-frame with a held output
    rdy = 1'b0;
    hold(7'h7E, 4'b0001, 6);
    hold(7'h30, 4'b0010, 6);
    hold(7'h6D, 4'b0100, 6);
    hold(7'h79, 4'b1000, 6);
    hold(7'h33, 4'b0001, 6);
    hold(7'h5B, 4'b0010, 6);
    check("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'h0);
    check("arst_value", 32'(bus.out_value), 32'h0);
    check("arst_err",   32'(bus.out_err),   32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy = 1'b1;
    hold(7'h7F, 4'b0001, 6);
    hold(7'h7B, 4'b0010, 6);
    hold(7'h77, 4'b0100, 6);
    hold(7'h1F, 4'b1000, 4);
    check("post_rst_value", 32'(bus.out_value), 32'hBA98);
    check("post_rst_valid", 32'(bus.out_valid), 32'h1);
    hold(7'h1F, 4'b1000, 2);

    // Randomized scan traffic with random backpressure
    rand_rdy = 1'b1;
    last_drv = {7'h1F, 4'b1000};
    nxt      = 0;
    for (int e = 0; e < 250; e++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        rd = 4'b0000;
      end else if (r < 17) begin
        rd = 4'($urandom_range(3, 15));
        while ($countones(rd) < 2) rd = 4'($urandom_range(3, 15));
      end else if (r < 75) begin
        rd  = 4'(1 << nxt);
        nxt = (nxt + 1) % ND;
      end else begin
        rd = 4'(1 << $urandom_range(0, ND - 1));
      end
      if ($urandom_range(0, 99) < 85) rs = pat_tab[$urandom_range(0, 15)];
      else rs = 7'($urandom_range(0, 127));
      if ({rs, rd} == last_drv) rs = rs ^ 7'h01;
      last_drv = {rs, rd};
      hold(rs, rd, int'($urandom_range(1, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
